// File: rtl/iir_channel_scheduler_pkg.sv
// Shared types and arithmetic helpers for the multiplexed IIR scheduler.
// The saturate helper is used when IIR_SAT_EN is defined.
package iir_sched_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GUARD_BITS = 3;
  localparam int ACC_W      = SAMPLE_W + GUARD_BITS;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(SAMPLE_W-1)));

  // Per-channel filter state: last two inputs, last three outputs.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] x1;
    logic signed [SAMPLE_W-1:0] x2;
    logic signed [SAMPLE_W-1:0] y1;
    logic signed [SAMPLE_W-1:0] y2;
    logic signed [SAMPLE_W-1:0] y3;
  } hist_t;

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [SAMPLE_W-1:0] res;
    if (v > SAT_MAX)      res = SAT_MAX[SAMPLE_W-1:0];
    else if (v < SAT_MIN) res = SAT_MIN[SAMPLE_W-1:0];
    else                  res = v[SAMPLE_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/iir_channel_scheduler_if.sv
// Bundle of per-channel sample inputs and the tagged result stream.
// master = sample source / result sink side, slave = scheduler side.
interface iir_channel_scheduler_if #(
  parameter int N_CH = 4,
  parameter int W    = 16
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic [N_CH-1:0]   ch_clear;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_ready;

  modport master (
    output in_valid, in_data, ch_clear, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, ch_clear, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/iir_channel_scheduler_arb.sv
// Round-robin arbiter: grants the first requester after the last winner.
// The pointer starts at N_CH-1 so channel 0 wins first after reset.
module iir_rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] gidx
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_cand;
  logic [CH_W-1:0] w_idx;
  logic            w_any;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    w_cand = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      w_cand = CH_W'((int'(r_ptr) + k) % N_CH);
      if (req[w_cand]) begin
        w_idx = w_cand;
        w_any = 1'b1;
      end
    end
    grant        = '0;
    grant[w_idx] = w_any;
  end

  assign gidx = w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= CH_W'(N_CH - 1);
    end else if (advance && w_any) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/iir_channel_scheduler.sv
// One IIR datapath shared across N_CH channels with round-robin grant and 1-cycle latency.
// Define IIR_SAT_EN to saturate results; otherwise results wrap. W must equal SAMPLE_W.
module iir_channel_scheduler
  import iir_sched_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = SAMPLE_W,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  iir_channel_scheduler_if.slave bus
);

  logic                       w_stall;
  logic [N_CH-1:0]            w_req;
  logic [N_CH-1:0]            w_grant;
  logic [CH_W-1:0]            w_gidx;
  logic                       w_any;
  logic signed [W-1:0]        w_in [N_CH];
  logic signed [W-1:0]        w_x;
  hist_t                      w_sel;
  hist_t                      w_new;
  logic signed [ACC_W-1:0]    w_xe, w_x1e, w_x2e, w_y1e, w_y2e, w_y3e;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [W-1:0]        w_y;

  hist_t                      r_hist [N_CH];
  logic                       r_out_valid;
  logic signed [W-1:0]        r_out_data;
  logic [CH_W-1:0]            r_out_ch;

  assign w_stall = r_out_valid & ~bus.out_ready;
  assign w_req   = bus.in_valid & {N_CH{~w_stall}};
  assign w_any   = |w_grant;

  iir_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (~w_stall),
    .grant   (w_grant),
    .gidx    (w_gidx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign w_in[gi] = bus.in_data[gi*W +: W];
    end
  endgenerate

  // A clear arriving with the grant makes the computation see zero history.
  assign w_x   = w_in[w_gidx];
  assign w_sel = bus.ch_clear[w_gidx] ? hist_t'('0) : r_hist[w_gidx];

  assign w_xe  = {{GUARD_BITS{w_x[W-1]}},              w_x};
  assign w_x1e = {{GUARD_BITS{w_sel.x1[SAMPLE_W-1]}}, w_sel.x1};
  assign w_x2e = {{GUARD_BITS{w_sel.x2[SAMPLE_W-1]}}, w_sel.x2};
  assign w_y1e = {{GUARD_BITS{w_sel.y1[SAMPLE_W-1]}}, w_sel.y1};
  assign w_y2e = {{GUARD_BITS{w_sel.y2[SAMPLE_W-1]}}, w_sel.y2};
  assign w_y3e = {{GUARD_BITS{w_sel.y3[SAMPLE_W-1]}}, w_sel.y3};

  assign w_sum = w_xe - w_x1e + w_x2e + w_y3e + (w_y1e >>> 1) + (w_y2e >>> 2);

`ifdef IIR_SAT_EN
  assign w_y = saturate(w_sum);
`else
  assign w_y = w_sum[W-1:0];
`endif

  always_comb begin
    w_new    = '0;
    w_new.x1 = w_x;
    w_new.x2 = w_sel.x1;
    w_new.y1 = w_y;
    w_new.y2 = w_sel.y1;
    w_new.y3 = w_sel.y2;
  end

  // Grant takes priority over a bare clear; w_new already folds the clear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_hist[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_grant[i])            r_hist[i] <= w_new;
        else if (bus.ch_clear[i])  r_hist[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (!w_stall) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_y;
        r_out_ch    <= w_gidx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;

endmodule
